muldiv_ctrl: RTL and testbench

Sequencer for the EX-stage multi-cycle arithmetic resources: the pipelined multiplier and the iterative divider. It accepts one mult/multu/div/divu request from EX and latches the operands. It drives the multiplier and the divider's start/annul/ready handshake and raises the EX stall request while the operation runs. It then emits a single-cycle HI/LO write with the 64-bit result.

---
 rtl/muldiv_ctrl.sv | 129 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the pipelined multiplier and the iterative divider.
// Latches one request, stalls EX while it runs, then emits a single HI/LO write.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a mult/multu/div/divu request from EX
// MUL_WAIT | operands held at multiplier, latency counter running down
// DIV_WAIT | divider started, waiting for its ready pulse
// DONE     | one-cycle HI/LO write of the captured result
module muldiv_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        flush,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_annul,
   output logic        div_signed,
   output logic [31:0] div_opdata1,
   output logic [31:0] div_opdata2,
   input  logic [63:0] div_result,
   input  logic        div_ready,
   output logic        stallreq,
   output logic        busy,
   output logic        hi_we,
   output logic        lo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [31:0]      src1_q;
   logic [31:0]      src2_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         src1_q <= '0;
         src2_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  op_q   <= req_op;
                  src1_q <= req_src1;
                  src2_q <= req_src2;
                  if (!req_op[1]) begin
                     state <= MUL_WAIT;
                     cnt   <= CNT_W'(MUL_LAT - 1);
                  end else if (req_src2 != 32'd0) begin
                     state <= DIV_WAIT;
                  end else begin
                     // divide by zero: divider is bypassed entirely
                     hi_q  <= req_src1;
                     lo_q  <= 32'hFFFF_FFFF;
                     state <= DONE;
                  end
               end
            end
            MUL_WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  hi_q  <= mul_result[63:32];
                  lo_q  <= mul_result[31:0];
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV_WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (div_ready) begin
                  hi_q  <= div_result[63:32];
                  lo_q  <= div_result[31:0];
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode the registered state; gated by rst so they read 0 in the reset cycle.
   logic in_mul;
   logic in_div;
   assign in_mul = !rst && (state == MUL_WAIT);
   assign in_div = !rst && (state == DIV_WAIT);

   assign mul_signed  = in_mul && (op_q == 2'b00);
   assign mul_ina     = in_mul ? src1_q : 32'd0;
   assign mul_inb     = in_mul ? src2_q : 32'd0;

   assign div_start   = in_div && !div_ready && !flush;
   assign div_annul   = in_div && flush;
   assign div_signed  = in_div && (op_q == 2'b10);
   assign div_opdata1 = in_div ? src1_q : 32'd0;
   assign div_opdata2 = in_div ? src2_q : 32'd0;

   assign stallreq = !rst && (((state == IDLE) && req_valid && !flush)
                              || (state == MUL_WAIT) || (state == DIV_WAIT));
   assign busy     = !rst && (state != IDLE);
   assign hi_we    = !rst && (state == DONE);
   assign lo_we    = !rst && (state == DONE);
   assign hi_wdata = rst ? 32'd0 : hi_q;
   assign lo_wdata = rst ? 32'd0 : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: simple multiplier/divider models, a vector table for
// single operations, and directed sequences for flush, reset and back-to-back issue.
module tb_muldiv_ctrl;

   localparam int MUL_LAT = 2;
   localparam int DIV_CYC = 33;
   localparam int NV      = 8;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        flush;
   logic        mul_signed;
   logic [31:0] mul_ina;
   logic [31:0] mul_inb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_annul;
   logic        div_signed;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic [63:0] div_result;
   logic        div_ready;
   logic        stallreq;
   logic        busy;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
      .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
      .mul_result(mul_result), .div_start(div_start), .div_annul(div_annul),
      .div_signed(div_signed), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
      .div_result(div_result), .div_ready(div_ready), .stallreq(stallreq),
      .busy(busy), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: one register stage, so a product is valid MUL_LAT=2 cycles after its inputs.
   logic [63:0] prod;
   logic [63:0] mul_q;
   always_comb begin
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{mul_ina[31]}}, mul_ina};
      sb = {{32{mul_inb[31]}}, mul_inb};
      if (mul_signed) prod = sa * sb;
      else            prod = {32'd0, mul_ina} * {32'd0, mul_inb};
   end
   always @(posedge clk) mul_q <= prod;
   assign mul_result = mul_q;

   // Divider model: ready pulse after DIV_CYC cycles of start.
   int dcnt;
   always @(posedge clk) begin
      if (rst || !div_start) dcnt <= 0;
      else                   dcnt <= dcnt + 1;
   end
   assign div_ready = (dcnt == DIV_CYC);
   always_comb begin
      div_result = 64'd0;
      if (div_opdata2 != 32'd0) begin
         if (div_signed)
            div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                          32'($signed(div_opdata1) / $signed(div_opdata2))};
         else
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_stall;
      int          exp_dstart;
      int          exp_msigned;
   } vec_t;

   vec_t vecs[NV];

   task automatic run_vec(input int idx, input vec_t v);
      int  stall;
      int  ds;
      int  ms;
      bit  done;
      stall = 0; ds = 0; ms = 0; done = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = v.op; req_src1 = v.src1; req_src2 = v.src2;
      for (int c = 0; c < 100 && !done; c++) begin
         #1;
         if (hi_we) begin
            done = 1;
            chk($sformatf("v%0d hi", idx), {32'd0, hi_wdata}, {32'd0, v.exp_hi});
            chk($sformatf("v%0d lo", idx), {32'd0, lo_wdata}, {32'd0, v.exp_lo});
            chk($sformatf("v%0d lo_we", idx), {63'd0, lo_we}, 64'd1);
            chk($sformatf("v%0d stall_in_done", idx), {63'd0, stallreq}, 64'd0);
         end else begin
            if (stallreq)   stall++;
            if (div_start)  ds++;
            if (mul_signed) ms++;
            @(negedge clk);
         end
      end
      chk($sformatf("v%0d done_seen", idx), {63'd0, done}, 64'd1);
      chk($sformatf("v%0d stall_cycles", idx), 64'(stall), 64'(v.exp_stall));
      chk($sformatf("v%0d div_start_cycles", idx), 64'(ds), 64'(v.exp_dstart));
      chk($sformatf("v%0d mul_signed_cycles", idx), 64'(ms), 64'(v.exp_msigned));
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk($sformatf("v%0d single_write", idx), {63'd0, hi_we}, 64'd0);
      chk($sformatf("v%0d idle_after", idx), {63'd0, busy}, 64'd0);
   endtask

   int          nw;
   int          extra;
   bit          just_wrote;
   logic [31:0] w_hi[2];
   logic [31:0] w_lo[2];

   initial begin
      //         op     src1          src2          hi            lo            stall  ds  ms
      vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 3,  0,  0};
      vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 3,  0,  2};
      vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 33, 0};
      vecs[3] = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1,  0,  0};
      vecs[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       35, 33, 0};
      vecs[5] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3,  0,  2};
      vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 35, 33, 0};
      vecs[7] = '{2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1,  0,  0};

      rst = 1'b1; flush = 1'b0;
      req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'h5; req_src2 = 32'h3;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", {56'd0, stallreq, busy, hi_we, lo_we, div_start, div_annul,
                         mul_signed, div_signed}, 64'd0);
      chk("reset_data", {32'd0, mul_ina | mul_inb | div_opdata1 | div_opdata2
                         | hi_wdata | lo_wdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // flush part-way through a divide
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd100; req_src2 = 32'd7;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("div_flush annul", {63'd0, div_annul}, 64'd1);
      chk("div_flush start", {63'd0, div_start}, 64'd0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk("div_flush idle", {62'd0, busy, div_annul}, 64'd0);
      nw = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (hi_we || lo_we) nw++;
      end
      chk("div_flush no_write", 64'(nw), 64'd0);

      // reset in the middle of a multiply
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd3; req_src2 = 32'd5;
      @(negedge clk); #1;
      chk("mul_rst busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mul_rst outs", {56'd0, stallreq, busy, hi_we, lo_we, div_start, div_annul,
                           mul_signed, div_signed}, 64'd0);
      chk("mul_rst data", {32'd0, mul_ina | mul_inb | hi_wdata | lo_wdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      #1;
      chk("mul_rst idle", {62'd0, busy, stallreq}, 64'd0);
      nw = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (hi_we) nw++;
      end
      chk("mul_rst no_write", 64'(nw), 64'd0);

      // flush in IDLE blocks acceptance
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd3; req_src2 = 32'd5; flush = 1'b1;
      #1;
      chk("idle_flush stall", {63'd0, stallreq}, 64'd0);
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #1;
      chk("idle_flush busy", {63'd0, busy}, 64'd0);

      // flush in DONE still writes
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'h55; req_src2 = 32'd0;
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("done_flush we", {62'd0, hi_we, lo_we}, 64'd3);
      chk("done_flush data", {hi_wdata, lo_wdata}, {32'h55, 32'hFFFFFFFF});
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk("done_flush idle", {63'd0, busy}, 64'd0);

      // multu then divu with req_valid held continuously
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'hFFFFFFFF; req_src2 = 32'd2;
      nw = 0; just_wrote = 0;
      for (int c = 0; c < 150 && nw < 2; c++) begin
         #1;
         if (just_wrote && nw == 1) chk("b2b accept", {63'd0, stallreq}, 64'd1);
         just_wrote = 0;
         if (hi_we) begin
            w_hi[nw] = hi_wdata; w_lo[nw] = lo_wdata;
            nw++;
            just_wrote = 1;
         end
         @(negedge clk);
         if (just_wrote) begin
            if (nw == 1) begin req_op = 2'b11; req_src1 = 32'd100; req_src2 = 32'd7; end
            else req_valid = 1'b0;
         end
      end
      extra = 0;
      repeat (10) begin
         #1;
         if (hi_we) extra++;
         @(negedge clk);
      end
      chk("b2b writes", 64'(nw + extra), 64'd2);
      chk("b2b first", {w_hi[0], w_lo[0]}, {32'h00000001, 32'hFFFFFFFE});
      chk("b2b second", {w_hi[1], w_lo[1]}, {32'd2, 32'd14});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
